// File: rtl/tb_irq_gen_pkg.sv
// Shared types for the testbench interrupt-stimulus generator.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package tb_irq_gen_pkg;

    // Per-channel lifecycle: disarmed, counting down to a fire, or waiting for acknowledge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PEND  = 2'd2
    } chan_state_e;

    // Trigger style of a channel: 1-cycle pulse or held until acknowledged.
    typedef enum logic {
        EDGE  = 1'b0,
        LEVEL = 1'b1
    } trig_mode_e;

    // Width of the optional per-channel fire counters.
    localparam int unsigned FireCntW = 16;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tb_irq_gen_chan.sv
// One interrupt channel: countdown timer, IDLE/COUNT/PEND state machine, sticky overrun flag.
// Latency: fires delay+1 cycles after a load; ack takes effect on the next cycle.
// Backpressure: none; load/kill/ack are single-cycle strobes always accepted (load > kill > ack).
// Optional TB_IRQ_GEN_STATS_EN adds a saturating 16-bit fire counter.
module tb_irq_gen_chan
    import tb_irq_gen_pkg::*;
#(
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned VsidW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 kill,
    input  logic                 ack,
    input  trig_mode_e           cfg_mode,
    input  logic [CntWidth-1:0]  cfg_delay,
    input  logic [CntWidth-1:0]  cfg_period,
    input  logic [PrioWidth-1:0] cfg_prio,
    input  logic [VsidW-1:0]     cfg_vsid,
`ifdef TB_IRQ_GEN_STATS_EN
    output logic [FireCntW-1:0]  fire_cnt,
`endif
    output logic                 irq,
    output logic                 pend,
    output logic [PrioWidth-1:0] prio,
    output logic [VsidW-1:0]     vsid,
    output logic                 overrun
);

    chan_state_e          state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;
    trig_mode_e           mode_q;
    logic [CntWidth-1:0]  period_q;
    logic [PrioWidth-1:0] prio_q;
    logic [VsidW-1:0]     vsid_q;

    logic                 periodic;
    logic                 expired;
    logic                 fire;
    logic [CntWidth-1:0]  reload;

    // Reloading with period-1 spaces consecutive expiries exactly 'period' cycles apart,
    // because the expiry cycle itself is the one where the counter reads zero.
    assign periodic = (period_q != '0);
    assign reload   = period_q - CntWidth'(1);
    assign expired  = (cnt_q == '0);
    assign fire     = (state_q == COUNT) && expired;

    // Next-state: timer progression, fire handling, ack handling; config overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        case (state_q)
            COUNT: begin
                if (expired) begin
                    cnt_d = periodic ? reload : '0;
                    if (mode_q == LEVEL) begin
                        state_d = PEND;
                    end else if (!periodic) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            PEND: begin
                if (periodic) begin
                    if (expired) begin
                        // The still-pending interrupt absorbs this expiry; an ack in the same
                        // cycle is consumed by the new expiry, so nothing is lost.
                        cnt_d = reload;
                        if (!ack) begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CntWidth'(1);
                        if (ack) begin
                            state_d = COUNT;
                        end
                    end
                end else if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        if (load) begin
            state_d = COUNT;
            cnt_d   = cfg_delay;
            ovr_d   = 1'b0;
        end
    end

    // State, counter and latched channel settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            mode_q   <= EDGE;
            period_q <= '0;
            prio_q   <= '0;
            vsid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            if (load) begin
                mode_q   <= cfg_mode;
                period_q <= cfg_period;
                prio_q   <= cfg_prio;
                vsid_q   <= cfg_vsid;
            end
        end
    end

`ifdef TB_IRQ_GEN_STATS_EN
    logic [FireCntW-1:0] fire_q;

    // Saturating fire count, restarted whenever the channel is re-armed.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            fire_q <= '0;
        end else if (fire && (fire_q != '1)) begin
            fire_q <= fire_q + FireCntW'(1);
        end
    end

    assign fire_cnt = rst ? '0 : fire_q;
`endif

    // Outputs are forced low while reset is asserted, before the registers have cleared.
    assign irq     = !rst && ((state_q == PEND) || fire);
    assign pend    = (state_q == PEND);
    assign prio    = (!rst && (state_q != IDLE)) ? prio_q : '0;
    assign vsid    = (!rst && (state_q != IDLE)) ? vsid_q : '0;
    assign overrun = !rst && ovr_q;

endmodule

// File: rtl/tb_irq_gen.sv
// Interrupt-stimulus generator: decodes config/ack requests onto NumChans channel engines.
// Latency: config applied next cycle; ack_err_o one cycle after the offending acknowledge.
// Backpressure: cfg_ready_o is 1 whenever not in reset; acknowledges are never stalled.
// Optional TB_IRQ_GEN_STATS_EN adds fire_cnt_o and an end-of-run count report.
module tb_irq_gen
    import tb_irq_gen_pkg::*;
#(
    parameter int unsigned  NumChans   = 8,
    parameter int unsigned  CntWidth   = 32,
    parameter int unsigned  PrioWidth  = 8,
    parameter int unsigned  NumVsctxts = 4,
    localparam int unsigned VsidW      = min1_clog2(NumVsctxts),
    localparam int unsigned IdxW       = min1_clog2(NumChans)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [IdxW-1:0]               cfg_chan_i,
    input  logic                          cfg_en_i,
    input  logic                          cfg_level_i,
    input  logic [CntWidth-1:0]           cfg_delay_i,
    input  logic [CntWidth-1:0]           cfg_period_i,
    input  logic [PrioWidth-1:0]          cfg_prio_i,
    input  logic [VsidW-1:0]              cfg_vsid_i,
    input  logic                          ack_valid_i,
    input  logic [IdxW-1:0]               ack_chan_i,
    output logic [NumChans-1:0]           irq_o,
    output logic [NumChans*PrioWidth-1:0] irq_prio_o,
    output logic [NumChans*VsidW-1:0]     irq_vsid_o,
    output logic                          ack_err_o,
`ifdef TB_IRQ_GEN_STATS_EN
    output logic [NumChans*FireCntW-1:0]  fire_cnt_o,
`endif
    output logic [NumChans-1:0]           overrun_o
);

    // Settings broadcast to every channel; only the selected one latches them.
    typedef struct packed {
        trig_mode_e           mode;
        logic [CntWidth-1:0]  delay;
        logic [CntWidth-1:0]  period;
        logic [PrioWidth-1:0] prio;
        logic [VsidW-1:0]     vsid;
    } chan_cfg_t;

    localparam logic [IdxW:0] ChanLimit = NumChans[IdxW:0];

    chan_cfg_t           cfg_req;
    logic                cfg_acc;
    logic                cfg_in_range;
    logic                ack_in_range;
    logic                ack_collide;
    logic                ack_err_d;
    logic                ack_err_q;
    logic [NumChans-1:0] cfg_sel;
    logic [NumChans-1:0] ack_sel;
    logic [NumChans-1:0] load;
    logic [NumChans-1:0] kill;
    logic [NumChans-1:0] ack_hit;
    logic [NumChans-1:0] pend_vec;

    assign cfg_ready_o  = !rst_i;
    assign cfg_acc      = cfg_valid_i && cfg_ready_o;
    assign cfg_in_range = ({1'b0, cfg_chan_i} < ChanLimit);
    assign ack_in_range = ({1'b0, ack_chan_i} < ChanLimit);

    assign cfg_req = '{
        mode:   trig_mode_e'(cfg_level_i),
        delay:  cfg_delay_i,
        period: cfg_period_i,
        prio:   cfg_prio_i,
        vsid:   cfg_vsid_i
    };

    // One-hot channel selects; out-of-range indices select nothing.
    always_comb begin
        cfg_sel = '0;
        ack_sel = '0;
        for (int i = 0; i < NumChans; i++) begin
            cfg_sel[i] = cfg_acc && cfg_in_range && (cfg_chan_i == IdxW'(i));
            ack_sel[i] = ack_valid_i && ack_in_range && (ack_chan_i == IdxW'(i));
        end
    end

    // A config to the acknowledged channel swallows the acknowledge silently.
    assign load        = cfg_sel & {NumChans{cfg_en_i}};
    assign kill        = cfg_sel & {NumChans{~cfg_en_i}};
    assign ack_hit     = ack_sel & ~cfg_sel;
    assign ack_collide = |(ack_sel & cfg_sel);
    assign ack_err_d   = ack_valid_i && !ack_collide && !(|(ack_sel & pend_vec));

    // Acknowledge error is a registered single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_d;
        end
    end

    assign ack_err_o = ack_err_q && !rst_i;

    for (genvar g = 0; g < NumChans; g++) begin : g_chan
        tb_irq_gen_chan #(
            .CntWidth  (CntWidth),
            .PrioWidth (PrioWidth),
            .VsidW     (VsidW)
        ) u_chan (
            .clk        (clk_i),
            .rst        (rst_i),
            .load       (load[g]),
            .kill       (kill[g]),
            .ack        (ack_hit[g]),
            .cfg_mode   (cfg_req.mode),
            .cfg_delay  (cfg_req.delay),
            .cfg_period (cfg_req.period),
            .cfg_prio   (cfg_req.prio),
            .cfg_vsid   (cfg_req.vsid),
`ifdef TB_IRQ_GEN_STATS_EN
            .fire_cnt   (fire_cnt_o[g*FireCntW +: FireCntW]),
`endif
            .irq        (irq_o[g]),
            .pend       (pend_vec[g]),
            .prio       (irq_prio_o[g*PrioWidth +: PrioWidth]),
            .vsid       (irq_vsid_o[g*VsidW +: VsidW]),
            .overrun    (overrun_o[g])
        );
    end

`ifdef TB_IRQ_GEN_STATS_EN
    // End-of-simulation summary of how often each channel fired.
    final begin
        for (int i = 0; i < NumChans; i++) begin
            $display("tb_irq_gen: channel %0d fired %0d times", i,
                     fire_cnt_o[i*FireCntW +: FireCntW]);
        end
    end
`endif

endmodule

// File: tb/tb_tb_irq_gen.sv
// Self-checking bench for tb_irq_gen: directed scenarios then random traffic vs. a timeline model.
// Six channels leave indices 6 and 7 representable but out of range.
module tb_tb_irq_gen;

    localparam int NC = 6;
    localparam int CW = 8;
    localparam int PW = 8;
    localparam int VW = 2;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [IW-1:0]    cfg_chan;
    logic             cfg_en;
    logic             cfg_level;
    logic [CW-1:0]    cfg_delay;
    logic [CW-1:0]    cfg_period;
    logic [PW-1:0]    cfg_prio;
    logic [VW-1:0]    cfg_vsid;
    logic             ack_valid;
    logic [IW-1:0]    ack_chan;
    logic [NC-1:0]    irq;
    logic [NC*PW-1:0] irq_prio;
    logic [NC*VW-1:0] irq_vsid;
    logic             ack_err;
    logic [NC-1:0]    overrun;
`ifdef TB_IRQ_GEN_STATS_EN
    logic [NC*16-1:0] fire_cnt;
`endif

    tb_irq_gen #(
        .NumChans   (NC),
        .CntWidth   (CW),
        .PrioWidth  (PW),
        .NumVsctxts (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_chan_i   (cfg_chan),
        .cfg_en_i     (cfg_en),
        .cfg_level_i  (cfg_level),
        .cfg_delay_i  (cfg_delay),
        .cfg_period_i (cfg_period),
        .cfg_prio_i   (cfg_prio),
        .cfg_vsid_i   (cfg_vsid),
        .ack_valid_i  (ack_valid),
        .ack_chan_i   (ack_chan),
        .irq_o        (irq),
        .irq_prio_o   (irq_prio),
        .irq_vsid_o   (irq_vsid),
        .ack_err_o    (ack_err),
`ifdef TB_IRQ_GEN_STATS_EN
        .fire_cnt_o   (fire_cnt),
`endif
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is described by absolute cycle numbers, not counters.
    bit          m_armed [NC];
    bit          m_pend  [NC];
    bit          m_level [NC];
    bit          m_ovr   [NC];
    int          m_period[NC];
    int          m_next  [NC];
    int          m_fires [NC];
    logic [PW-1:0] m_prio[NC];
    logic [VW-1:0] m_vsid[NC];
    bit          m_err;
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NC-1:0]    e_irq;
        logic [NC-1:0]    e_ovr;
        logic [NC*PW-1:0] e_prio;
        logic [NC*VW-1:0] e_vsid;
        logic [NC*16-1:0] e_cnt;
        e_irq  = '0;
        e_ovr  = '0;
        e_prio = '0;
        e_vsid = '0;
        e_cnt  = '0;
        for (int i = 0; i < NC; i++) begin
            if (!rst) begin
                e_irq[i] = m_pend[i] || (m_armed[i] && (m_next[i] == cyc));
                e_ovr[i] = m_ovr[i];
                e_cnt[i*16 +: 16] = 16'(m_fires[i]);
                if (m_armed[i] || m_pend[i]) begin
                    e_prio[i*PW +: PW] = m_prio[i];
                    e_vsid[i*VW +: VW] = m_vsid[i];
                end
            end
        end
        chk("cfg_ready", 64'(cfg_ready), 64'(!rst));
        chk("irq", 64'(irq), 64'(e_irq));
        chk("irq_prio", 64'(irq_prio), 64'(e_prio));
        chk("irq_vsid", 64'(irq_vsid), 64'(e_vsid));
        chk("overrun", 64'(overrun), 64'(e_ovr));
        chk("ack_err", 64'(ack_err), 64'(!rst && m_err));
`ifdef TB_IRQ_GEN_STATS_EN
        chk("fire_cnt", 64'(fire_cnt[63:0]), 64'(e_cnt[63:0]));
        chk("fire_cnt_hi", 64'(fire_cnt[NC*16-1:64]), 64'(e_cnt[NC*16-1:64]));
`endif
    endtask

    // Advance the model over the clock edge closing cycle 'cyc'.
    task automatic model_update();
        bit cfg_hit;
        bit err_n;
        bit a;
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                m_armed[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; m_level[i] = 0;
                m_period[i] = 0; m_next[i] = 0; m_fires[i] = 0;
                m_prio[i] = '0; m_vsid[i] = '0;
            end
            m_err = 0;
            return;
        end
        cfg_hit = cfg_valid && (int'(cfg_chan) < NC);
        err_n = 0;
        if (ack_valid) begin
            if (int'(ack_chan) >= NC) err_n = 1;
            else if (!(cfg_hit && cfg_chan == ack_chan) && !m_pend[ack_chan]) err_n = 1;
        end
        for (int i = 0; i < NC; i++) begin
            a = ack_valid && (int'(ack_chan) == i) && !(cfg_hit && int'(cfg_chan) == i);
            if (m_pend[i]) begin
                if (m_period[i] > 0 && m_next[i] == cyc) begin
                    m_next[i] += m_period[i];
                    if (!a) m_ovr[i] = 1;
                end else if (a) begin
                    m_pend[i]  = 0;
                    m_armed[i] = (m_period[i] > 0);
                end
            end else if (m_armed[i] && m_next[i] == cyc) begin
                if (m_fires[i] < 65535) m_fires[i]++;
                if (m_period[i] > 0) m_next[i] = cyc + m_period[i];
                else m_armed[i] = 0;
                if (m_level[i]) begin
                    m_pend[i]  = 1;
                    m_armed[i] = 0;
                end
            end
        end
        if (cfg_hit) begin
            if (cfg_en) begin
                m_armed[cfg_chan]  = 1;
                m_pend[cfg_chan]   = 0;
                m_ovr[cfg_chan]    = 0;
                m_next[cfg_chan]   = cyc + 1 + int'(cfg_delay);
                m_level[cfg_chan]  = cfg_level;
                m_period[cfg_chan] = int'(cfg_period);
                m_prio[cfg_chan]   = cfg_prio;
                m_vsid[cfg_chan]   = cfg_vsid;
                m_fires[cfg_chan]  = 0;
            end else begin
                m_armed[cfg_chan] = 0;
                m_pend[cfg_chan]  = 0;
            end
        end
        m_err = err_n;
    endtask

    // Check the current cycle, clock it, and leave the bench 1 time unit into the next cycle.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        cfg_valid = 1'b0;
        ack_valid = 1'b0;
    endtask

    task automatic cfg_drive(input int ch, input bit en, input bit lvl, input int dly,
                             input int per, input int pr, input int vs);
        cfg_valid  = 1'b1;
        cfg_chan   = IW'(ch);
        cfg_en     = en;
        cfg_level  = lvl;
        cfg_delay  = CW'(dly);
        cfg_period = CW'(per);
        cfg_prio   = PW'(pr);
        cfg_vsid   = VW'(vs);
    endtask

    task automatic ack_drive(input int ch);
        ack_valid = 1'b1;
        ack_chan  = IW'(ch);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; m_err = 0;
        rst = 1'b1;
        cfg_valid = 0; cfg_chan = '0; cfg_en = 0; cfg_level = 0; cfg_delay = '0;
        cfg_period = '0; cfg_prio = '0; cfg_vsid = '0; ack_valid = 0; ack_chan = '0;
        step();
        step();
        rst = 1'b0;

        // Edge one-shot on channel 2, accepted at cycle 10: pulse only at cycle 16.
        while (cyc < 10) step();
        cfg_drive(2, 1, 0, 5, 0, 8'hA5, 3);
        step();
        repeat (4) step();
        chk("edge_before", 64'(irq[2]), 64'(0));
        step();
        chk("edge_fire", 64'(irq[2]), 64'(1));
        chk("edge_prio", 64'(irq_prio[2*PW +: PW]), 64'(8'hA5));
        step();
        chk("edge_once", 64'(irq[2]), 64'(0));
        chk("edge_prio_clr", 64'(irq_prio[2*PW +: PW]), 64'(0));
        chk("edge_vsid_clr", 64'(irq_vsid[2*VW +: VW]), 64'(0));

        // Level periodic on channel 0, delay 0, period 4, acknowledged at t+3.
        cfg_drive(0, 1, 1, 0, 4, 8'h11, 1);
        step();
        chk("lvl_first", 64'(irq[0]), 64'(1));
        step();
        step();
        ack_drive(0);
        step();
        chk("lvl_ack_low", 64'(irq[0]), 64'(0));
        step();
        chk("lvl_refire", 64'(irq[0]), 64'(1));
        chk("lvl_no_ovr", 64'(overrun[0]), 64'(0));
        cfg_drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("lvl_disabled", 64'(irq[0]), 64'(0));

        // Overrun on channel 1: level, period 3, left unacknowledged.
        cfg_drive(1, 1, 1, 0, 3, 8'h22, 2);
        step();
        chk("ovr_fire", 64'(irq[1]), 64'(1));
        step();
        step();
        chk("ovr_not_yet", 64'(overrun[1]), 64'(0));
        step();
        step();
        chk("ovr_set", 64'(overrun[1]), 64'(1));
        chk("ovr_irq_held", 64'(irq[1]), 64'(1));
        ack_drive(1);
        step();
        chk("ovr_ack_low", 64'(irq[1]), 64'(0));
        chk("ovr_sticky", 64'(overrun[1]), 64'(1));
        cfg_drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("ovr_kept_on_disable", 64'(overrun[1]), 64'(1));

        // Acknowledge errors: idle channel, then out-of-range channel.
        ack_drive(3);
        step();
        chk("ackerr_idle", 64'(ack_err), 64'(1));
        step();
        chk("ackerr_pulse", 64'(ack_err), 64'(0));
        ack_drive(7);
        step();
        chk("ackerr_range", 64'(ack_err), 64'(1));
        step();

        // Config and acknowledge on channel 4 together: config wins, no error.
        cfg_drive(4, 1, 0, 2, 0, 8'h44, 0);
        ack_drive(4);
        step();
        chk("coll_no_err", 64'(ack_err), 64'(0));
        step();
        step();
        chk("coll_cfg_fire", 64'(irq[4]), 64'(1));

        // Expiry and acknowledge in the same cycle on channel 5: stays pending.
        cfg_drive(5, 1, 1, 0, 2, 8'h55, 3);
        step();
        step();
        step();
        ack_drive(5);
        step();
        chk("exp_ack_irq", 64'(irq[5]), 64'(1));
        chk("exp_ack_ovr", 64'(overrun[5]), 64'(0));
        chk("exp_ack_err", 64'(ack_err), 64'(0));

        // Reset mid-operation with every channel armed.
        for (int i = 0; i < NC; i++) begin
            cfg_drive(i, 1, i % 2, i, 2 + i, 16 * i + 1, i);
            step();
        end
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(cfg_ready), 64'(0));
        chk("rst_irq", 64'(irq), 64'(0));
        chk("rst_prio", 64'(irq_prio), 64'(0));
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_irq", 64'(irq), 64'(0));
        chk("post_rst_prio", 64'(irq_prio), 64'(0));
        chk("post_rst_ovr", 64'(overrun), 64'(0));
`ifdef TB_IRQ_GEN_STATS_EN
        chk("post_rst_cnt", 64'(fire_cnt[63:0]), 64'(0));
`endif
        repeat (8) step();

        // Random traffic against the model.
        repeat (3000) begin
            if ($urandom_range(0, 4) == 0) begin
                cfg_drive(int'($urandom_range(0, 7)), ($urandom_range(0, 5) != 0),
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 2) == 0) begin
                ack_drive(int'($urandom_range(0, 7)));
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
